// File: rtl/alu_pkg.sv
// Shared definitions for the ALU and its issue sequencer: default widths,
// opcode encodings and the sequencer state type.
package alu_pkg;

   localparam int ALU_DATA_W = 8;
   localparam int ALU_SEL_W  = 4;

   localparam logic [ALU_SEL_W-1:0] ALU_OP_ADD = 4'b0000;
   localparam logic [ALU_SEL_W-1:0] ALU_OP_SUB = 4'b0001;
   localparam logic [ALU_SEL_W-1:0] ALU_OP_SHL = 4'b0100;
   localparam logic [ALU_SEL_W-1:0] ALU_OP_SHR = 4'b0101;
   localparam logic [ALU_SEL_W-1:0] ALU_OP_AND = 4'b1000;
   localparam logic [ALU_SEL_W-1:0] ALU_OP_OR  = 4'b1001;
   localparam logic [ALU_SEL_W-1:0] ALU_OP_XOR = 4'b1010;
   localparam logic [ALU_SEL_W-1:0] ALU_OP_EQ  = 4'b1111;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      RESP   = 2'd2
   } issue_state_e;

endpackage

// File: rtl/alu.sv
// Combinational ALU. The top bit of ALU_Result is the carry/borrow out for
// arithmetic and the shifted-out bit for left shift.
module alu
   import alu_pkg::*;
#(
   parameter int DATA_W = ALU_DATA_W
) (
   input  logic [DATA_W-1:0]    A,
   input  logic [DATA_W-1:0]    B,
   input  logic [ALU_SEL_W-1:0] ALU_Sel,
   output logic [DATA_W:0]      ALU_Result
);

   // Opcode decode; unknown opcodes pass operand A through.
   always_comb begin
      ALU_Result = {1'b0, A};
      case (ALU_Sel)
         ALU_OP_ADD: ALU_Result = {1'b0, A} + {1'b0, B};
         ALU_OP_SUB: ALU_Result = {1'b0, A} - {1'b0, B};
         ALU_OP_SHL: ALU_Result = {A, 1'b0};
         ALU_OP_SHR: ALU_Result = {2'b00, A[DATA_W-1:1]};
         ALU_OP_AND: ALU_Result = {1'b0, A & B};
         ALU_OP_OR:  ALU_Result = {1'b0, A | B};
         ALU_OP_XOR: ALU_Result = {1'b0, A ^ B};
         ALU_OP_EQ:  ALU_Result = (A == B) ? (DATA_W+1)'(1) : '0;
         default:    ALU_Result = {1'b0, A};
      endcase
   end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue sequencer for the combinational ALU: registers one request's operands,
// waits for the ALU to settle, captures result and flags, and hands them back
// over a valid/ready response port. Keeps an accumulator for chained ops.
module alu_issue_ctrl
   import alu_pkg::*;
#(
   parameter int DATA_W     = ALU_DATA_W,
   parameter int SEL_W      = ALU_SEL_W,
   parameter int SETTLE_CYC = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [DATA_W-1:0] req_a,
   input  logic [DATA_W-1:0] req_b,
   input  logic [SEL_W-1:0]  req_sel,
   input  logic              req_acc,
   input  logic              acc_clr,
   output logic [DATA_W-1:0] alu_a,
   output logic [DATA_W-1:0] alu_b,
   output logic [SEL_W-1:0]  alu_sel,
   input  logic [DATA_W:0]   alu_result,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W:0]   rsp_result,
   output logic              rsp_zero,
   output logic              rsp_carry,
   output logic [15:0]       op_count
);

   // Settle counter only needs to hold SETTLE_CYC-1.
   localparam int              CNT_W    = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(SETTLE_CYC - 1);

   issue_state_e      state_reg;
   logic [CNT_W-1:0]  cnt_reg;
   logic [DATA_W-1:0] acc_reg;
   logic [DATA_W-1:0] alu_a_reg;
   logic [DATA_W-1:0] alu_b_reg;
   logic [SEL_W-1:0]  alu_sel_reg;
   logic              rsp_valid_reg;
   logic [DATA_W:0]   rsp_result_reg;
   logic              rsp_zero_reg;
   logic              rsp_carry_reg;
   logic [15:0]       op_count_reg;
   logic [DATA_W-1:0] operand_a;

   // Ready is masked by reset so nothing can be accepted during a reset cycle.
   assign req_ready = (state_reg == IDLE) && !rst;

   // Operand A source: a coincident clear overrides the stored accumulator.
   assign operand_a = req_acc ? (acc_clr ? '0 : acc_reg) : req_a;

   // Sequencer FSM with all datapath registers; outputs come straight from flops.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg      <= IDLE;
         cnt_reg        <= '0;
         acc_reg        <= '0;
         alu_a_reg      <= '0;
         alu_b_reg      <= '0;
         alu_sel_reg    <= '0;
         rsp_valid_reg  <= 1'b0;
         rsp_result_reg <= '0;
         rsp_zero_reg   <= 1'b0;
         rsp_carry_reg  <= 1'b0;
         op_count_reg   <= '0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (acc_clr) begin
                  acc_reg <= '0;
               end
               if (req_valid && req_ready) begin
                  alu_a_reg   <= operand_a;
                  alu_b_reg   <= req_b;
                  alu_sel_reg <= req_sel;
                  cnt_reg     <= CNT_INIT;
                  state_reg   <= SETTLE;
               end
            end
            SETTLE: begin
               if (cnt_reg != '0) begin
                  cnt_reg <= cnt_reg - 1'b1;
               end else begin
                  rsp_result_reg <= alu_result;
                  rsp_zero_reg   <= (alu_result[DATA_W-1:0] == '0);
                  rsp_carry_reg  <= alu_result[DATA_W];
                  acc_reg        <= alu_result[DATA_W-1:0];
                  op_count_reg   <= op_count_reg + 16'd1;
                  rsp_valid_reg  <= 1'b1;
                  state_reg      <= RESP;
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid_reg <= 1'b0;
                  state_reg     <= IDLE;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign alu_a      = alu_a_reg;
   assign alu_b      = alu_b_reg;
   assign alu_sel    = alu_sel_reg;
   assign rsp_valid  = rsp_valid_reg;
   assign rsp_result = rsp_result_reg;
   assign rsp_zero   = rsp_zero_reg;
   assign rsp_carry  = rsp_carry_reg;
   assign op_count   = op_count_reg;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl paired with the ALU: a table of chained
// ADD operations plus hand-written back-pressure, reset and SETTLE_CYC=3 runs.
module tb_alu_issue_ctrl;
   import alu_pkg::*;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   int         cyc = 0;
   int         checks = 0;
   int         errors = 0;

   // Shared request inputs
   logic [7:0] req_a = '0;
   logic [7:0] req_b = '0;
   logic [3:0] req_sel = ALU_OP_ADD;
   logic       req_acc = 1'b0;
   logic       acc_clr = 1'b0;

   // Instance with SETTLE_CYC=1
   logic       req_valid1 = 1'b0, rsp_ready1 = 1'b0;
   logic       req_ready1, rsp_valid1, rsp_zero1, rsp_carry1;
   logic [7:0] alu_a1, alu_b1;
   logic [3:0] alu_sel1;
   logic [8:0] alu_result1, rsp_result1;
   logic [15:0] op_count1;

   // Instance with SETTLE_CYC=3
   logic       req_valid3 = 1'b0, rsp_ready3 = 1'b0;
   logic       req_ready3, rsp_valid3, rsp_zero3, rsp_carry3;
   logic [7:0] alu_a3, alu_b3;
   logic [3:0] alu_sel3;
   logic [8:0] alu_result3, rsp_result3;
   logic [15:0] op_count3;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   alu_issue_ctrl #(.DATA_W(8), .SEL_W(4), .SETTLE_CYC(1)) dut1 (
      .clk(clk), .rst(rst),
      .req_valid(req_valid1), .req_ready(req_ready1),
      .req_a(req_a), .req_b(req_b), .req_sel(req_sel),
      .req_acc(req_acc), .acc_clr(acc_clr),
      .alu_a(alu_a1), .alu_b(alu_b1), .alu_sel(alu_sel1),
      .alu_result(alu_result1),
      .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready1),
      .rsp_result(rsp_result1), .rsp_zero(rsp_zero1), .rsp_carry(rsp_carry1),
      .op_count(op_count1)
   );
   alu #(.DATA_W(8)) u_alu1 (.A(alu_a1), .B(alu_b1), .ALU_Sel(alu_sel1), .ALU_Result(alu_result1));

   alu_issue_ctrl #(.DATA_W(8), .SEL_W(4), .SETTLE_CYC(3)) dut3 (
      .clk(clk), .rst(rst),
      .req_valid(req_valid3), .req_ready(req_ready3),
      .req_a(req_a), .req_b(req_b), .req_sel(req_sel),
      .req_acc(req_acc), .acc_clr(acc_clr),
      .alu_a(alu_a3), .alu_b(alu_b3), .alu_sel(alu_sel3),
      .alu_result(alu_result3),
      .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3),
      .rsp_result(rsp_result3), .rsp_zero(rsp_zero3), .rsp_carry(rsp_carry3),
      .op_count(op_count3)
   );
   alu #(.DATA_W(8)) u_alu3 (.A(alu_a3), .B(alu_b3), .ALU_Sel(alu_sel3), .ALU_Result(alu_result3));

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic       use_acc;
      logic       clr;
      logic [7:0] exp_alu_a;
      logic [8:0] exp_res;
      logic       exp_zero;
      logic       exp_carry;
      logic [7:0] exp_acc;
   } vec_t;

   vec_t vecs[8];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Present a request on one instance and wait (bounded) for the handshake.
   // t returns the cycle in which the handshake was present.
   task automatic issue(input bit use3, input logic [7:0] a, input logic [7:0] b,
                        input logic use_acc, input logic clr, output int t);
      bit done;
      @(negedge clk);
      req_a = a; req_b = b; req_acc = use_acc; acc_clr = clr; req_sel = ALU_OP_ADD;
      if (use3) req_valid3 = 1'b1; else req_valid1 = 1'b1;
      done = 1'b0;
      t = -1;
      for (int i = 0; i < 20 && !done; i++) begin
         if ((use3 ? req_ready3 : req_ready1) === 1'b1) begin
            t = cyc;
            @(posedge clk);
            #1;
            done = 1'b1;
         end else begin
            @(negedge clk);
         end
      end
      req_valid1 = 1'b0; req_valid3 = 1'b0; acc_clr = 1'b0;
      check("accept_timeout", {31'd0, done}, 32'd1);
   endtask

   // Wait (bounded) for rsp_valid, return cycles since the handshake cycle.
   task automatic wait_rsp(input bit use3, input int t, output int lat);
      lat = -1;
      for (int i = 0; i < 20 && lat < 0; i++) begin
         if ((use3 ? rsp_valid3 : rsp_valid1) === 1'b1) lat = cyc - t;
         else begin
            @(posedge clk);
            #1;
         end
      end
      check("rsp_timeout", {31'd0, lat >= 0}, 32'd1);
   endtask

   // Consume the pending response with a one-cycle rsp_ready pulse.
   task automatic consume(input bit use3);
      @(negedge clk);
      if (use3) rsp_ready3 = 1'b1; else rsp_ready1 = 1'b1;
      @(posedge clk);
      #1;
      check("rsp_valid_after_consume", {31'd0, use3 ? rsp_valid3 : rsp_valid1}, 32'd0);
      rsp_ready1 = 1'b0; rsp_ready3 = 1'b0;
   endtask

   initial begin
      int t, lat;
      vecs[0] = '{8'hF0, 8'h0F, 1'b0, 1'b0, 8'hF0, 9'h0FF, 1'b0, 1'b0, 8'hFF};
      vecs[1] = '{8'hFF, 8'hFF, 1'b0, 1'b0, 8'hFF, 9'h1FE, 1'b0, 1'b1, 8'hFE};
      vecs[2] = '{8'hFF, 8'h00, 1'b0, 1'b0, 8'hFF, 9'h0FF, 1'b0, 1'b0, 8'hFF};
      vecs[3] = '{8'h55, 8'h01, 1'b1, 1'b0, 8'hFF, 9'h100, 1'b1, 1'b1, 8'h00};
      vecs[4] = '{8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 9'h000, 1'b1, 1'b0, 8'h00};
      vecs[5] = '{8'hAA, 8'h05, 1'b1, 1'b0, 8'h00, 9'h005, 1'b0, 1'b0, 8'h05};
      vecs[6] = '{8'h99, 8'h07, 1'b1, 1'b1, 8'h00, 9'h007, 1'b0, 1'b0, 8'h07};
      vecs[7] = '{8'h11, 8'h22, 1'b0, 1'b0, 8'h11, 9'h033, 1'b0, 1'b0, 8'h33};

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("reset_req_ready", {31'd0, req_ready1}, 32'd0);
      check("reset_rsp_valid", {31'd0, rsp_valid1}, 32'd0);
      check("reset_op_count", {16'd0, op_count1}, 32'd0);
      check("reset_alu_a", {24'd0, alu_a1}, 32'd0);
      check("reset_rsp_result", {23'd0, rsp_result1}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("idle_req_ready", {31'd0, req_ready1}, 32'd1);

      // Table of chained ADD operations
      for (int i = 0; i < 8; i++) begin
         issue(1'b0, vecs[i].a, vecs[i].b, vecs[i].use_acc, vecs[i].clr, t);
         check("alu_a", {24'd0, alu_a1}, {24'd0, vecs[i].exp_alu_a});
         check("alu_b", {24'd0, alu_b1}, {24'd0, vecs[i].b});
         check("alu_sel", {28'd0, alu_sel1}, {28'd0, ALU_OP_ADD});
         wait_rsp(1'b0, t, lat);
         check("latency", lat, 32'd2);
         check("rsp_result", {23'd0, rsp_result1}, {23'd0, vecs[i].exp_res});
         check("rsp_zero", {31'd0, rsp_zero1}, {31'd0, vecs[i].exp_zero});
         check("rsp_carry", {31'd0, rsp_carry1}, {31'd0, vecs[i].exp_carry});
         check("acc", {24'd0, dut1.acc_reg}, {24'd0, vecs[i].exp_acc});
         check("op_count", {16'd0, op_count1}, i + 1);
         $display("vec %0d: a=%02h b=%02h acc=%0b clr=%0b -> result=%03h z=%0b c=%0b lat=%0d",
                  i, vecs[i].a, vecs[i].b, vecs[i].use_acc, vecs[i].clr,
                  rsp_result1, rsp_zero1, rsp_carry1, lat);
         consume(1'b0);
      end

      // Back-pressure: response held, a waiting request is not accepted,
      // and acc_clr outside IDLE is ignored.
      issue(1'b0, 8'h01, 8'h02, 1'b0, 1'b0, t);
      wait_rsp(1'b0, t, lat);
      @(negedge clk);
      req_a = 8'h0A; req_b = 8'h14; req_acc = 1'b0; req_valid1 = 1'b1; acc_clr = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         check("stall_rsp_valid", {31'd0, rsp_valid1}, 32'd1);
         check("stall_rsp_result", {23'd0, rsp_result1}, 32'h003);
         check("stall_req_ready", {31'd0, req_ready1}, 32'd0);
         check("stall_alu_a", {24'd0, alu_a1}, 32'h01);
      end
      acc_clr = 1'b0;
      check("stall_op_count", {16'd0, op_count1}, 32'd9);
      check("stall_acc_kept", {24'd0, dut1.acc_reg}, 32'h03);
      $display("stall: result=%03h held, op_count=%0d", rsp_result1, op_count1);
      @(negedge clk);
      rsp_ready1 = 1'b1;
      @(posedge clk);
      #1;
      rsp_ready1 = 1'b0;
      check("release_rsp_valid", {31'd0, rsp_valid1}, 32'd0);
      check("release_req_ready", {31'd0, req_ready1}, 32'd1);
      t = cyc;
      @(posedge clk);
      #1;
      req_valid1 = 1'b0;
      check("reaccept_req_ready", {31'd0, req_ready1}, 32'd0);
      check("reaccept_alu_a", {24'd0, alu_a1}, 32'h0A);
      check("reaccept_alu_b", {24'd0, alu_b1}, 32'h14);
      wait_rsp(1'b0, t, lat);
      check("reaccept_latency", lat, 32'd2);
      check("reaccept_result", {23'd0, rsp_result1}, 32'h01E);
      check("reaccept_op_count", {16'd0, op_count1}, 32'd10);
      $display("reaccept: a=0a b=14 -> result=%03h lat=%0d", rsp_result1, lat);
      consume(1'b0);

      // acc_clr alone in IDLE
      @(negedge clk);
      acc_clr = 1'b1;
      @(posedge clk);
      #1;
      acc_clr = 1'b0;
      check("idle_acc_clr", {24'd0, dut1.acc_reg}, 32'd0);
      $display("acc_clr in idle: acc=%02h", dut1.acc_reg);

      // Reset during SETTLE abandons the operation
      issue(1'b0, 8'h05, 8'h06, 1'b0, 1'b0, t);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("rst_rsp_valid", {31'd0, rsp_valid1}, 32'd0);
      check("rst_op_count", {16'd0, op_count1}, 32'd0);
      check("rst_alu_a", {24'd0, alu_a1}, 32'd0);
      check("rst_alu_b", {24'd0, alu_b1}, 32'd0);
      check("rst_acc", {24'd0, dut1.acc_reg}, 32'd0);
      check("rst_req_ready", {31'd0, req_ready1}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("post_rst_req_ready", {31'd0, req_ready1}, 32'd1);
      repeat (3) begin
         @(posedge clk);
         #1;
         check("post_rst_no_rsp", {31'd0, rsp_valid1}, 32'd0);
      end
      $display("reset mid-op: rsp_valid=%0b op_count=%0d", rsp_valid1, op_count1);

      // SETTLE_CYC=3 instance, A=240 B=15
      issue(1'b1, 8'hF0, 8'h0F, 1'b0, 1'b0, t);
      wait_rsp(1'b1, t, lat);
      check("s3_latency", lat, 32'd4);
      check("s3_result", {23'd0, rsp_result3}, 32'h0FF);
      check("s3_zero", {31'd0, rsp_zero3}, 32'd0);
      check("s3_carry", {31'd0, rsp_carry3}, 32'd0);
      check("s3_op_count", {16'd0, op_count3}, 32'd1);
      $display("settle3: a=f0 b=0f -> result=%03h lat=%0d", rsp_result3, lat);
      consume(1'b1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
